clk_divider_prog: RTL and testbench

Programmable, runtime-reloadable successor to the fixed-range clock divider. Counts `0..div` at `i_clk` and emits a one-cycle `o_impulse` on each wrap. Adds a divisor load handshake with shadow register (glitch-free reload at wrap), count enable, periodic/one-shot modes and an optional square-wave output. Feeds the display scan and BCD refresh logic as a shared tick source whose rate firmware-side control logic can retune without reset.

---
 rtl/clk_divider_prog.sv | 102 ++++++++++
 tb/tb_clk_divider_prog.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_prog.sv
// Programmable tick divider: counts 0..div, pulses on wrap, reloads its divisor glitch-free via a shadow register.
// Optional square-wave output is built when CLK_DIVIDER_PROG_TOGGLE_EN is defined; otherwise o_toggle is tied 0.
module clk_divider_prog #(
    parameter int                 P_WIDTH       = 26,
    parameter logic [P_WIDTH-1:0] P_DEFAULT_DIV = P_WIDTH'(255)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_mode,
    input  logic               i_start,
    input  logic               i_div_valid,
    input  logic [P_WIDTH-1:0] i_div,
    output logic               o_div_ready,
    output logic [P_WIDTH-1:0] o_count,
    output logic               o_impulse,
    output logic               o_busy,
    output logic               o_toggle
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [P_WIDTH-1:0] count_q;
    logic [P_WIDTH-1:0] div_q;
    logic [P_WIDTH-1:0] shadow_q;
    logic               shadow_full_q;
    logic               mode_q;       // 1 = one-shot
    logic               impulse_q;
    logic               wrap;
    logic               accept;

    assign wrap   = (state_q == ST_RUN) && i_enable && (count_q == div_q);
    assign accept = i_div_valid && !shadow_full_q;

    // NOTE: next-state logic starts from a full default so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_enable && (!mode_q || i_start)) state_d = ST_RUN;
            ST_RUN:  if (wrap && mode_q)                   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Idle and wrap cycles are the only reload points for the active divisor and mode.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            count_q       <= '0;
            impulse_q     <= 1'b0;
            mode_q        <= i_mode;
            div_q         <= P_DEFAULT_DIV;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            impulse_q <= wrap;
            if (state_q == ST_IDLE || wrap) begin
                count_q <= '0;
                mode_q  <= i_mode;
                if (shadow_full_q) begin
                    div_q         <= shadow_q;
                    shadow_full_q <= 1'b0;
                end else if (accept) begin
                    div_q <= i_div;
                end
            end else begin
                if (i_enable) count_q <= count_q + 1'b1;
                if (accept) begin
                    shadow_q      <= i_div;
                    shadow_full_q <= 1'b1;
                end
            end
        end
    end

`ifdef CLK_DIVIDER_PROG_TOGGLE_EN
    logic toggle_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset)  toggle_q <= 1'b0;
        else if (wrap) toggle_q <= ~toggle_q;
    end

    assign o_toggle = toggle_q;
`else
    assign o_toggle = 1'b0;
`endif

    assign o_div_ready = !shadow_full_q;
    assign o_count     = count_q;
    assign o_impulse   = impulse_q;
    assign o_busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: directed scenarios with literal timing expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_clk_divider_prog;

    localparam int W = 26;

    logic         clk = 1'b0;
    logic         reset, enable, mode, start, div_valid;
    logic [W-1:0] div;
    logic         o_div_ready, o_impulse, o_busy, o_toggle;
    logic [W-1:0] o_count;

    always #5 clk = ~clk;

    clk_divider_prog #(.P_WIDTH(W), .P_DEFAULT_DIV(W'(255))) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_enable    (enable),
        .i_mode      (mode),
        .i_start     (start),
        .i_div_valid (div_valid),
        .i_div       (div),
        .o_div_ready (o_div_ready),
        .o_count     (o_count),
        .o_impulse   (o_impulse),
        .o_busy      (o_busy),
        .o_toggle    (o_toggle)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle", name, act, exp);
        end
    endtask

    // Behavioural model: running flag, position in period, active divisor and a pending-divisor queue.
    bit m_busy, m_imp, m_tog, m_mode, m_last_acc;
    int m_cnt, m_div;
    int m_pend[$];

    task automatic model_step();
        bit acc;
        m_last_acc = 1'b0;
        if (!reset) begin
            m_busy = 0; m_imp = 0; m_tog = 0; m_cnt = 0; m_div = 255;
            m_pend.delete();
            m_mode = mode;
            return;
        end
        acc        = div_valid && (m_pend.size() == 0);
        m_last_acc = acc;
        if (!m_busy) begin
            m_imp = 0;
            m_cnt = 0;
            if (acc) m_div = int'(div);
            if (enable && (!m_mode || start)) m_busy = 1;
            m_mode = mode;
        end else if (!enable) begin
            m_imp = 0;
            if (acc) m_pend.push_back(int'(div));
        end else if (m_cnt == m_div) begin
            m_imp = 1;
            m_tog = !m_tog;
            m_cnt = 0;
            if (m_pend.size() > 0) m_div = m_pend.pop_front();
            else if (acc)          m_div = int'(div);
            if (m_mode) m_busy = 0;
            m_mode = mode;
        end else begin
            m_imp = 0;
            m_cnt++;
            if (acc) m_pend.push_back(int'(div));
        end
    endtask

    int cyc = 0;
    int busy_cycles = 0;
    int pulses[$];
    int tog_rises[$];
    bit tog_prev = 1'b0;

    task automatic cycle();
        bit exp_tog;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
`ifdef CLK_DIVIDER_PROG_TOGGLE_EN
        exp_tog = m_tog;
`else
        exp_tog = 1'b0;
`endif
        check("count",   32'(o_count), 32'(m_cnt));
        check("impulse", 32'(o_impulse), 32'(m_imp));
        check("busy",    32'(o_busy), 32'(m_busy));
        check("ready",   32'(o_div_ready), 32'(m_pend.size() == 0));
        check("toggle",  32'(o_toggle), 32'(exp_tog));
        if (o_impulse) pulses.push_back(cyc);
        if (o_busy) busy_cycles++;
        if (o_toggle && !tog_prev) tog_rises.push_back(cyc);
        tog_prev = o_toggle;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k = 0;
        while (pulses.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check("wait_pulses", 32'(pulses.size() >= n), 32'd1);
    endtask

    task automatic wait_count(input int v, input int budget);
        int k = 0;
        while (int'(o_count) != v && k < budget) begin
            cycle();
            k++;
        end
        check("wait_count", 32'(o_count), 32'(v));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    task automatic load_idle_div(input int d);
        enable    = 1'b0;
        div_valid = 1'b1;
        div       = W'(d);
        cycle();
        div_valid = 1'b0;
    endtask

    initial begin
        int n0;
        int guard;
        reset = 0; enable = 0; mode = 0; start = 0; div_valid = 0; div = '0;
        repeat (2) cycle();
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_impulse", 32'(o_impulse), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ready", 32'(o_div_ready), 32'd1);
        check("rst_toggle", 32'(o_toggle), 32'd0);

        // Default divisor: first pulse 257 cycles after release, then every 256.
        enable = 1; reset = 1; cyc = 0; pulses.delete();
        wait_pulses(2, 600);
        check("first_pulse_default", 32'(pulses[0]), 32'd257);
        check("period_default", 32'(pulses[1] - pulses[0]), 32'd256);

        // div=4, reload to 9 at count 2: one more 5-cycle period then 10.
        do_reset();
        load_idle_div(4);
        enable = 1; pulses.delete();
        wait_pulses(2, 50);
        wait_count(2, 20);
        div_valid = 1; div = W'(9);
        cycle();
        div_valid = 0;
        check("ready_low_after_accept", 32'(o_div_ready), 32'd0);
        wait_pulses(5, 60);
        check("period_old_div", 32'(pulses[2] - pulses[1]), 32'd5);
        check("period_new_div_a", 32'(pulses[3] - pulses[2]), 32'd10);
        check("period_new_div_b", 32'(pulses[4] - pulses[3]), 32'd10);

        // Back-to-back writes: 3 then 6; second held off until the wrap.
        wait_count(3, 20);
        div_valid = 1; div = W'(3);
        cycle();
        div = W'(6);
        guard = 0;
        cycle();
        while (!m_last_acc && guard < 40) begin
            cycle();
            guard++;
        end
        div_valid = 0;
        check("b2b_second_held", 32'(guard > 0), 32'd1);
        wait_pulses(8, 60);
        check("b2b_period_old", 32'(pulses[5] - pulses[4]), 32'd10);
        check("b2b_period_new1", 32'(pulses[6] - pulses[5]), 32'd4);
        check("b2b_period_new2", 32'(pulses[7] - pulses[6]), 32'd7);

        // One-shot div=3: pulse 5 cycles after start, busy 4 cycles, retrigger ignored.
        mode = 1;
        do_reset();
        load_idle_div(3);
        enable = 1;
        cycle();
        check("oneshot_waits_start", 32'(o_busy), 32'd0);
        pulses.delete(); busy_cycles = 0; n0 = cyc;
        start = 1; cycle();
        start = 0; cycle();
        start = 1; cycle();
        start = 0;
        repeat (12) cycle();
        check("oneshot_pulse_count", 32'(pulses.size()), 32'd1);
        check("oneshot_latency", 32'(pulses[0] - n0), 32'd5);
        check("oneshot_busy_cycles", 32'(busy_cycles), 32'd4);

        // Enable low 7 cycles at count 6 with div=9: period stretches to 17.
        mode = 0;
        do_reset();
        load_idle_div(9);
        enable = 1; pulses.delete();
        wait_pulses(1, 30);
        wait_count(6, 20);
        enable = 0;
        repeat (7) cycle();
        check("hold_count", 32'(o_count), 32'd6);
        check("hold_busy", 32'(o_busy), 32'd1);
        enable = 1;
        wait_pulses(2, 30);
        check("stretched_period", 32'(pulses[1] - pulses[0]), 32'd17);

        // div=1 square wave.
        do_reset();
        load_idle_div(1);
        enable = 1; tog_rises.delete();
        repeat (20) cycle();
`ifdef CLK_DIVIDER_PROG_TOGGLE_EN
        check("toggle_active", 32'(tog_rises.size() >= 2), 32'd1);
        check("toggle_period", 32'(tog_rises[1] - tog_rises[0]), 32'd4);
`else
        check("toggle_tied_low", 32'(tog_rises.size()), 32'd0);
`endif

        // Reset mid-count with a pending shadow value discards everything.
        wait_count(0, 5);
        div_valid = 1; div = W'(7);
        cycle();
        div_valid = 0;
        check("shadow_full_before_reset", 32'(o_div_ready), 32'd0);
        reset = 0;
        cycle();
        check("midrst_count", 32'(o_count), 32'd0);
        check("midrst_impulse", 32'(o_impulse), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_ready", 32'(o_div_ready), 32'd1);
        check("midrst_toggle", 32'(o_toggle), 32'd0);
        reset = 1; cyc = 0; pulses.delete();
        wait_pulses(1, 300);
        check("first_pulse_after_midrst", 32'(pulses[0]), 32'd257);

        // Randomized traffic against the model.
        repeat (3000) begin
            reset     = ($urandom_range(0, 299) != 0);
            enable    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            start     = ($urandom_range(0, 7) == 0);
            div_valid = ($urandom_range(0, 5) == 0);
            div       = W'($urandom_range(0, 12));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
